player_hit_ctl: RTL and testbench
=================================

Name: player_hit_ctl

Overview:
- Receiving end of the enemy-missile interface. Takes one enemy missile's position and alive flag, plus the player ship position.
- Detects a missile/ship overlap and decrements the player's lives.
- Returns a one-cycle hit_ack to the enemy missile controller so that controller retires the missile.
- After each hit, grants an invulnerability window counted in frames. Asserts game_over when lives reach zero.
- Sits between the enemy block outputs and the player draw/lives logic.

Parameters:
- PLAYER_W, 64, player ship width in pixels
- PLAYER_H, 48, player ship height in pixels
- MISSILE_W, 4, enemy missile width in pixels
- MISSILE_H, 12, enemy missile height in pixels
- LIVES_INIT, 3, lives loaded at reset/restart (1..7)
- INVULN_FRAMES, 120, frames of invulnerability after a non-fatal hit (1..255)

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- vsync_in  in  1  vertical sync; its rising edge is the frame tick
- xpos_missile_en  in  11  enemy missile left x
- ypos_missile_en  in  11  enemy missile top y
- on_missile_en  in  1  enemy missile in flight
- xpos_player  in  11  player ship left x
- ypos_player  in  11  player ship top y
- restart  in  1  level-sampled synchronous restart request
- hit_ack  out  1  one-cycle pulse: missile hit player, retire it
- lives  out  3  remaining lives
- invuln  out  1  high while invulnerable
- player_visible  out  1  draw-enable for the player ship
- game_over  out  1  high when lives == 0

Behaviour:
- Reset (rst = 0, asynchronous) sets:
  - lives = LIVES_INIT
  - hit_ack = 0, invuln = 0, game_over = 0
  - player_visible = 1
  - state = ALIVE, frame counter = 0, internal registers = 0
- Frame tick: vsync_in registered once; tick = vsync_q & ~vsync_q2. The tick is one cycle wide, once per frame.
- Overlap is evaluated in 12-bit unsigned arithmetic, so no wrap at 2047. It is true iff on_missile_en = 1 AND all four of these hold:
  - xpos_missile_en <= xpos_player + PLAYER_W - 1
  - xpos_player <= xpos_missile_en + MISSILE_W - 1
  - ypos_missile_en <= ypos_player + PLAYER_H - 1
  - ypos_player <= ypos_missile_en + MISSILE_H - 1
- Edge-touching rectangles count as overlap.
- The overlap result is registered into hit_det.
- ALIVE state: if hit_det = 1, go to HIT.
- HIT state (exactly one cycle):
  - hit_ack = 1 and lives <= lives - 1, both on the edge entering HIT.
  - If lives was 1, the next state is DEAD; otherwise it is INVULN.
- Latency: if overlap first holds in input cycle N, hit_ack is high in cycle N+2. It stays high for one cycle only, even if the overlap persists.
- INVULN state:
  - invuln = 1, frame counter cleared on entry.
  - The counter increments on each tick; overlaps are ignored and produce no hit_ack.
  - When the counter reaches INVULN_FRAMES - 1 and a tick occurs, go to ALIVE with invuln = 0.
  - A hit_det that is still high on the return to ALIVE causes a new hit: the missile must have been retired by then.
- DEAD state:
  - game_over = 1, lives = 0, player_visible = 0.
  - Overlaps are ignored; the block stays here until restart.
- restart = 1 in any state, sampled on a clock edge:
  - Next state ALIVE, lives = LIVES_INIT, counter = 0.
  - invuln = 0, game_over = 0, player_visible = 1, hit_ack = 0.
  - restart has priority over a simultaneous hit.
- lives never underflows: decrement occurs only in HIT, and HIT is reachable only with lives >= 1.
- A mid-operation rst from any state immediately forces the reset values.
- player_visible = 1 in ALIVE, HIT and INVULN (see the optional feature); 0 in DEAD.

Optional Feature:
- Macro: PLAYER_BLINK_EN.
- When defined, in INVULN player_visible = ~counter[3], so the ship blinks with an 8-frame on/off period starting visible. All other states are unchanged.
- When undefined, player_visible = 1 throughout INVULN.

Test Plan:
- Reset, then release rst: lives = 3, game_over = 0, invuln = 0, player_visible = 1, hit_ack = 0.
- Player at (400,700), missile at (430,690) with on = 1: hit_ack pulses 1 cycle at N+2, lives = 2, invuln = 1. Hold the overlap: no second ack for 120 ticks, then invuln = 0.
- Missile at (464,700), exactly 1 px right of the ship edge at 463: no ack. Missile at (463,700): ack. Same overlap with on = 0: no ack.
- Three hits, each separated by a full invulnerability window: lives 3→2→1→0, game_over = 1, player_visible = 0. A fourth overlap gives no ack and no underflow.
- In DEAD, pulse restart for 1 cycle: lives = 3, game_over = 0. Assert restart in the same cycle as hit_det: no ack, lives = 3.
- With PLAYER_BLINK_EN defined: after a hit, player_visible is 1 for ticks 0-7, 0 for ticks 8-15, then repeats. Assert rst low mid-INVULN: all outputs take reset values immediately.

Source files
------------

// File: rtl/player_hit_ctl.sv
// Player hit controller: missile/ship overlap detection, lives, invulnerability window, game over.
// Optional PLAYER_BLINK_EN makes the ship blink while invulnerable.
module player_hit_ctl #(
   parameter int PLAYER_W      = 64,
   parameter int PLAYER_H      = 48,
   parameter int MISSILE_W     = 4,
   parameter int MISSILE_H     = 12,
   parameter int LIVES_INIT    = 3,
   parameter int INVULN_FRAMES = 120
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic [10:0] xpos_missile_en,
   input  logic [10:0] ypos_missile_en,
   input  logic        on_missile_en,
   input  logic [10:0] xpos_player,
   input  logic [10:0] ypos_player,
   input  logic        restart,
   output logic        hit_ack,
   output logic [2:0]  lives,
   output logic        invuln,
   output logic        player_visible,
   output logic        game_over
);

   typedef enum logic [1:0] {ALIVE, HIT, INVULN, DEAD} state_t;

   localparam logic [11:0] PW_M1    = 12'(PLAYER_W - 1);
   localparam logic [11:0] PH_M1    = 12'(PLAYER_H - 1);
   localparam logic [11:0] MW_M1    = 12'(MISSILE_W - 1);
   localparam logic [11:0] MH_M1    = 12'(MISSILE_H - 1);
   localparam logic [2:0]  LIVES_RST = 3'(LIVES_INIT);
   localparam logic [7:0]  INV_LAST = 8'(INVULN_FRAMES - 1);

   state_t      state_q, state_d;
   logic [2:0]  lives_q, lives_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ack_q, ack_d;
   logic        vsync_q, vsync_q2, hit_det_q;
   logic        tick, overlap;
   logic [11:0] mx, my, px, py;

   assign tick = vsync_q & ~vsync_q2;

   // 12-bit compare so right/bottom edges near 2047 cannot wrap
   assign mx = {1'b0, xpos_missile_en};
   assign my = {1'b0, ypos_missile_en};
   assign px = {1'b0, xpos_player};
   assign py = {1'b0, ypos_player};
   assign overlap = on_missile_en &
                    (mx <= px + PW_M1) & (px <= mx + MW_M1) &
                    (my <= py + PH_M1) & (py <= my + MH_M1);

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q   <= ALIVE;
         lives_q   <= LIVES_RST;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         vsync_q   <= 1'b0;
         vsync_q2  <= 1'b0;
         hit_det_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         vsync_q   <= vsync_in;
         vsync_q2  <= vsync_q;
         hit_det_q <= overlap;
      end
   end

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      if (restart) begin
         state_d = ALIVE;
         lives_d = LIVES_RST;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ALIVE: if (hit_det_q) begin
               state_d = HIT;
               ack_d   = 1'b1;
               lives_d = lives_q - 3'd1;
            end
            // lives already decremented on entry, so zero means that was the last one
            HIT: begin
               cnt_d   = '0;
               state_d = (lives_q == 3'd0) ? DEAD : INVULN;
            end
            INVULN: if (tick) begin
               if (cnt_q == INV_LAST) begin
                  state_d = ALIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            DEAD: lives_d = 3'd0;
            default: state_d = ALIVE;
         endcase
      end
   end

   assign hit_ack   = ack_q;
   assign lives     = lives_q;
   assign invuln    = (state_q == INVULN);
   assign game_over = (state_q == DEAD);

`ifdef PLAYER_BLINK_EN
   assign player_visible = (state_q == DEAD)   ? 1'b0 :
                           (state_q == INVULN) ? ~cnt_q[3] : 1'b1;
`else
   assign player_visible = (state_q != DEAD);
`endif

endmodule

// File: tb/tb_player_hit_ctl.sv
// Directed bench for player_hit_ctl; hit_ack events are checked against a scoreboard of expected lives.
module tb_player_hit_ctl;

   logic        pclk = 1'b0;
   logic        rst;
   logic        vsync_in;
   logic [10:0] xpos_missile_en, ypos_missile_en, xpos_player, ypos_player;
   logic        on_missile_en, restart;
   logic        hit_ack, invuln, player_visible, game_over;
   logic [2:0]  lives;

   int n_chk  = 0;
   int n_fail = 0;
   logic [2:0] exp_q[$];

   always #5 pclk = ~pclk;

   player_hit_ctl dut (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
      .xpos_missile_en(xpos_missile_en), .ypos_missile_en(ypos_missile_en),
      .on_missile_en(on_missile_en), .xpos_player(xpos_player),
      .ypos_player(ypos_player), .restart(restart), .hit_ack(hit_ack),
      .lives(lives), .invuln(invuln), .player_visible(player_visible),
      .game_over(game_over)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Every ack must match a pending scoreboard entry carrying the lives it should leave
   always @(negedge pclk) begin
      if (rst === 1'b1 && hit_ack === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_ack", 32'(hit_ack), 32'd0);
         else chk("sb_lives_at_ack", 32'(lives), 32'(exp_q.pop_front()));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic frame();
      vsync_in = 1'b1;
      cyc(3);
      vsync_in = 1'b0;
      cyc(3);
   endtask

   task automatic set_m(input int x, input int y, input logic on);
      xpos_missile_en = 11'(x);
      ypos_missile_en = 11'(y);
      on_missile_en   = on;
   endtask

   // Overlap driven in cycle N; ack expected exactly in N+2 and only then
   task automatic hit(input int x, input int y, input logic [2:0] exp_lives);
      exp_q.push_back(exp_lives);
      set_m(x, y, 1'b1);
      @(negedge pclk); chk("ack_n0", 32'(hit_ack), 32'd0);
      cyc(1);
      @(negedge pclk); chk("ack_n1", 32'(hit_ack), 32'd0);
      cyc(1);
      @(negedge pclk); chk("ack_n2", 32'(hit_ack), 32'd1);
      chk("lives_n2", 32'(lives), 32'(exp_lives));
      cyc(1);
      @(negedge pclk); chk("ack_n3", 32'(hit_ack), 32'd0);
      cyc(1);
   endtask

   // Walk the full invulnerability window, dropping the missile before the last tick
   task automatic window(input string tag);
      for (int k = 1; k < 120; k++) begin
         frame();
         if (k == 1 || k == 119) chk({tag, "_invuln_hold"}, 32'(invuln), 32'd1);
`ifdef PLAYER_BLINK_EN
         if (k < 20) chk({tag, "_blink"}, 32'(player_visible), 32'(((k >> 3) & 1) == 0));
`else
         if (k < 20) chk({tag, "_visible"}, 32'(player_visible), 32'd1);
`endif
      end
      set_m(0, 0, 1'b0);
      cyc(3);
      frame();
      chk({tag, "_invuln_end"}, 32'(invuln), 32'd0);
   endtask

   initial begin
      rst = 1'b0; vsync_in = 1'b0; restart = 1'b0;
      xpos_player = 11'd400; ypos_player = 11'd700;
      set_m(0, 0, 1'b0);
      cyc(3);
      chk("rst_lives", 32'(lives), 32'd3);
      rst = 1'b1;
      cyc(2);
      chk("rel_lives", 32'(lives), 32'd3);
      chk("rel_game_over", 32'(game_over), 32'd0);
      chk("rel_invuln", 32'(invuln), 32'd0);
      chk("rel_visible", 32'(player_visible), 32'd1);
      chk("rel_ack", 32'(hit_ack), 32'd0);

      // first hit, overlap held through the whole window
      hit(430, 690, 3'd2);
      chk("hit1_invuln", 32'(invuln), 32'd1);
      window("w1");
      chk("w1_lives", 32'(lives), 32'd2);

      // one pixel past right edge, then exact edge with missile off
      set_m(464, 700, 1'b1);
      cyc(5);
      chk("edge_miss_lives", 32'(lives), 32'd2);
      set_m(463, 700, 1'b0);
      cyc(5);
      chk("off_lives", 32'(lives), 32'd2);
      hit(463, 700, 3'd1);
      window("w2");

      // last life
      hit(430, 690, 3'd0);
      chk("dead_game_over", 32'(game_over), 32'd1);
      chk("dead_visible", 32'(player_visible), 32'd0);
      chk("dead_lives", 32'(lives), 32'd0);
      cyc(6);
      chk("dead_no_underflow", 32'(lives), 32'd0);

      set_m(0, 0, 1'b0);
      cyc(2);
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      chk("restart_lives", 32'(lives), 32'd3);
      chk("restart_game_over", 32'(game_over), 32'd0);
      chk("restart_visible", 32'(player_visible), 32'd1);

      // restart in the cycle hit_det is high wins over the hit
      set_m(430, 690, 1'b1);
      cyc(1);
      restart = 1'b1;
      set_m(0, 0, 1'b0);
      cyc(1);
      restart = 1'b0;
      cyc(4);
      chk("restart_prio_lives", 32'(lives), 32'd3);
      chk("restart_prio_ack", 32'(hit_ack), 32'd0);

      // async reset in the middle of the window
      hit(430, 690, 3'd2);
      set_m(0, 0, 1'b0);
      repeat (10) frame();
      chk("mid_invuln", 32'(invuln), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_lives", 32'(lives), 32'd3);
      chk("arst_invuln", 32'(invuln), 32'd0);
      chk("arst_visible", 32'(player_visible), 32'd1);
      chk("arst_game_over", 32'(game_over), 32'd0);
      chk("arst_ack", 32'(hit_ack), 32'd0);
      cyc(2);
      rst = 1'b1;
      cyc(4);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
